// File: rtl/line_option_generator.sv
// rtl/line_option_generator.sv - enumerates every legal run placement of one nonogram clue
// and packs them into a single line-FIFO word.
module line_option_generator #(
  parameter int SIZE     = 11,
  parameter int MAX_RUNS = 6,
  parameter int RUN_W    = 4,
  parameter int IDX_W    = 5,
  parameter int CNT_W    = 7,
  parameter int LINE_W   = 1024,
  parameter int MAX_OPTS = 92
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [IDX_W-1:0]              line_idx,
  input  logic [$clog2(MAX_RUNS+1)-1:0] run_count,
  input  logic [MAX_RUNS*RUN_W-1:0]     runs,
  input  logic                          fifo_full,
  output logic                          write_to_fifo,
  output logic [LINE_W-1:0]             dout,
  output logic                          busy,
  output logic                          err_infeasible,
  output logic                          err_overflow
);

  localparam int RC_W  = $clog2(MAX_RUNS+1);
  localparam int OPT_W = LINE_W - IDX_W - CNT_W;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_INIT = 2'd1;
  localparam logic [1:0] S_EMIT = 2'd2;
  localparam logic [1:0] S_PUSH = 2'd3;

  logic [1:0]       state_q;
  logic [IDX_W-1:0] idx_q;
  logic [RC_W-1:0]  rc_q;
  logic [RUN_W-1:0] len_q   [MAX_RUNS];
  logic [RUN_W-1:0] start_q [MAX_RUNS];
  logic [CNT_W-1:0] cnt_q;
  logic [OPT_W-1:0] opts_q;
  logic             err_inf_q;
  logic             err_ovf_q;

  int               need;
  logic             infeasible;
  logic [RUN_W-1:0] pack    [MAX_RUNS];
  int               lim     [MAX_RUNS];
  logic             found;
  int               kk;
  logic [RUN_W-1:0] nxt     [MAX_RUNS];
  logic [SIZE-1:0]  mask;
  int               slot_top;

  assign in_ready       = (state_q == S_IDLE);
  assign busy           = (state_q != S_IDLE);
  assign write_to_fifo  = (state_q == S_PUSH) && !fifo_full;
  assign err_infeasible = err_inf_q;
  assign err_overflow   = err_ovf_q;
  assign dout           = {idx_q, cnt_q, opts_q};

  // Feasibility: zero-length runs, too many runs, or total span wider than the line.
  always_comb begin
    need       = 0;
    infeasible = (int'(rc_q) > MAX_RUNS);
    for (int i = 0; i < MAX_RUNS; i++) begin
      if (i < int'(rc_q)) begin
        need = need + int'(len_q[i]);
        if (i > 0) need = need + 1;
        if (len_q[i] == '0) infeasible = 1'b1;
      end
    end
    if (need > SIZE) infeasible = 1'b1;
  end

  always_comb begin
    pack[0] = '0;
    for (int j = 1; j < MAX_RUNS; j++) begin
      pack[j] = RUN_W'(int'(pack[j-1]) + int'(len_q[j-1]) + 1);
    end
  end

  // Each run may slide right until it touches the gap before its successor.
  always_comb begin
    for (int k = 0; k < MAX_RUNS - 1; k++) begin
      lim[k] = int'(start_q[k+1]) - 1;
    end
    lim[MAX_RUNS-1] = SIZE;
    found = 1'b0;
    kk    = 0;
    for (int k = 0; k < MAX_RUNS; k++) begin
      if (k < int'(rc_q)) begin
        if (k == int'(rc_q) - 1) lim[k] = SIZE;
        if (int'(start_q[k]) + int'(len_q[k]) < lim[k]) begin
          found = 1'b1;
          kk    = k;
        end
      end
    end
  end

  always_comb begin
    nxt[0] = (kk == 0) ? RUN_W'(int'(start_q[0]) + 1) : start_q[0];
    for (int j = 1; j < MAX_RUNS; j++) begin
      if (j < kk)       nxt[j] = start_q[j];
      else if (j == kk) nxt[j] = RUN_W'(int'(start_q[j]) + 1);
      else              nxt[j] = RUN_W'(int'(nxt[j-1]) + int'(len_q[j-1]) + 1);
    end
  end

  always_comb begin
    mask = '0;
    for (int c = 0; c < SIZE; c++) begin
      for (int i = 0; i < MAX_RUNS; i++) begin
        if (i < int'(rc_q) && c >= int'(start_q[i]) &&
            c < int'(start_q[i]) + int'(len_q[i])) begin
          mask[SIZE-1-c] = 1'b1;
        end
      end
    end
    slot_top = OPT_W - 1 - int'(cnt_q) * SIZE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      rc_q      <= '0;
      cnt_q     <= '0;
      opts_q    <= '0;
      err_inf_q <= 1'b0;
      err_ovf_q <= 1'b0;
      for (int i = 0; i < MAX_RUNS; i++) begin
        len_q[i]   <= '0;
        start_q[i] <= '0;
      end
    end else begin
      err_inf_q <= 1'b0;
      err_ovf_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            idx_q  <= line_idx;
            rc_q   <= run_count;
            cnt_q  <= '0;
            opts_q <= '0;
            for (int i = 0; i < MAX_RUNS; i++) begin
              len_q[i] <= runs[i*RUN_W +: RUN_W];
            end
            state_q <= S_INIT;
          end
        end
        S_INIT: begin
          if (infeasible) begin
            err_inf_q <= 1'b1;
            state_q   <= S_IDLE;
          end else begin
            start_q <= pack;
            state_q <= S_EMIT;
          end
        end
        S_EMIT: begin
          if (cnt_q == CNT_W'(MAX_OPTS)) begin
            err_ovf_q <= 1'b1;
            state_q   <= S_IDLE;
          end else begin
            opts_q[slot_top -: SIZE] <= mask;
            cnt_q <= cnt_q + 1'b1;
            if (rc_q == '0 || !found) state_q <= S_PUSH;
            else                      start_q <= nxt;
          end
        end
        default: begin
          if (!fifo_full) state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_line_option_generator.sv
// tb/tb_line_option_generator.sv - directed clues checked against a brute-force mask enumeration model.
module tb_line_option_generator;

  localparam int SIZE = 11;
  localparam int LW   = 1024;
  localparam int OTOP = LW - 5 - 7 - 1;

  logic           clk = 0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [4:0]     line_idx;
  logic [2:0]     run_count;
  logic [23:0]    runs;
  logic           fifo_full;
  logic           write_to_fifo;
  logic [LW-1:0]  dout;
  logic           busy;
  logic           err_infeasible;
  logic           err_overflow;

  line_option_generator dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .line_idx(line_idx), .run_count(run_count), .runs(runs),
    .fifo_full(fifo_full), .write_to_fifo(write_to_fifo), .dout(dout),
    .busy(busy), .err_infeasible(err_infeasible), .err_overflow(err_overflow)
  );

  always #5 clk = ~clk;

  typedef struct { int kind; logic [LW-1:0] word; } exp_t;
  exp_t exp_q[$];

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int n_events = 0;
  int n_writes = 0;
  int ev_cyc = 0;
  int acc = 0;
  logic [LW-1:0] last_word;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic check_word(input string name, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    int b;
    tests++;
    if (got !== exp) begin
      fails++;
      b = 0;
      for (int i = LW - 1; i >= 0; i--) if (got[i] !== exp[i]) begin b = i; break; end
      $display("FAIL %s: first differing bit %0d, got[%0d+:32]=%h expected %h",
               name, b, (b / 32) * 32, got[(b / 32) * 32 +: 32], exp[(b / 32) * 32 +: 32]);
    end
  endtask

  function automatic logic [6:0] get_n(input logic [LW-1:0] w);
    return w[LW-6 -: 7];
  endfunction

  function automatic logic [10:0] get_opt(input logic [LW-1:0] w, input int k);
    return w[OTOP - k * SIZE -: SIZE];
  endfunction

  // Every line mask whose run pattern equals the clue, in descending mask order.
  function automatic void model(input logic [4:0] idx, input logic [2:0] rc, input logic [23:0] rv,
                                output int kind, output logic [LW-1:0] w);
    int lens[6];
    int runl[12];
    int n, nr, cur;
    bit ok;
    logic [10:0] m;
    kind = 0;
    w = '0;
    n = 0;
    if (int'(rc) > 6) kind = 1;
    for (int i = 0; i < 6; i++) begin
      lens[i] = int'(rv[i*4 +: 4]);
      if (i < int'(rc) && lens[i] == 0) kind = 1;
    end
    if (kind != 0) return;
    for (int v = 2047; v >= 0; v--) begin
      m = 11'(v);
      nr = 0;
      cur = 0;
      for (int c = 0; c <= SIZE; c++) begin
        if (c < SIZE && m[SIZE-1-c]) cur++;
        else if (cur > 0) begin
          runl[nr] = cur;
          nr++;
          cur = 0;
        end
      end
      ok = (nr == int'(rc));
      for (int i = 0; i < nr && ok; i++) if (runl[i] != lens[i]) ok = 0;
      if (ok) begin
        if (n < 92) w[OTOP - n * SIZE -: SIZE] = m;
        n++;
      end
    end
    if (n == 0) kind = 1;
    else if (n > 92) kind = 2;
    else begin
      w[LW-1 -: 5] = idx;
      w[LW-6 -: 7] = 7'(n);
    end
  endfunction

  always @(negedge clk) begin
    if (!rst && (write_to_fifo || err_infeasible || err_overflow)) begin
      exp_t e;
      int k;
      n_events++;
      ev_cyc = cyc;
      k = write_to_fifo ? 0 : (err_infeasible ? 1 : 2);
      check("exclusive_event", 64'(int'(write_to_fifo) + int'(err_infeasible) + int'(err_overflow)), 64'd1);
      if (write_to_fifo) begin
        n_writes++;
        last_word = dout;
      end
      if (exp_q.size() == 0) begin
        check("unexpected_event", 64'(k), 64'd99);
      end else begin
        e = exp_q.pop_front();
        check("event_kind", 64'(k), 64'(e.kind));
        if (write_to_fifo && e.kind == 0) check_word("dout_word", dout, e.word);
      end
    end
  end

  task automatic send(input logic [4:0] idx, input logic [2:0] rc, input logic [23:0] rv);
    exp_t e;
    int t;
    t = 0;
    while (!in_ready && t < 300) begin
      @(posedge clk); #1;
      t++;
    end
    check("in_ready_wait", 64'(in_ready), 64'd1);
    model(idx, rc, rv, e.kind, e.word);
    exp_q.push_back(e);
    line_idx = idx;
    run_count = rc;
    runs = rv;
    in_valid = 1;
    @(posedge clk); #1;
    acc = cyc;
    in_valid = 0;
  endtask

  task automatic wait_event(input int budget);
    int start;
    int t;
    start = n_events;
    t = 0;
    while (n_events == start && t < budget) begin
      @(posedge clk); #1;
      t++;
    end
    check("event_timeout", 64'(n_events > start), 64'd1);
  endtask

  task automatic clue(input logic [4:0] idx, input logic [2:0] rc, input logic [23:0] rv);
    send(idx, rc, rv);
    wait_event(300);
  endtask

  initial begin
    logic [LW-1:0] d0;
    logic [LW-1:0] low;
    bit stable;
    int w0, e0;

    rst = 1; in_valid = 0; line_idx = 0; run_count = 0; runs = 0; fifo_full = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_write", 64'(write_to_fifo), 64'd0);
    check("rst_errs", 64'({err_infeasible, err_overflow}), 64'd0);
    check_word("rst_dout", dout, '0);
    rst = 0;
    @(posedge clk); #1;

    clue(5'd3, 3'd1, 24'h000003);
    check("lat_3", 64'(ev_cyc + 1 - acc), 64'd11);
    check("idx_3", 64'(last_word[LW-1 -: 5]), 64'd3);
    check("n_3", 64'(get_n(last_word)), 64'd9);
    check("opt0_3", 64'(get_opt(last_word, 0)), 64'b11100000000);
    check("opt8_3", 64'(get_opt(last_word, 8)), 64'b00000000111);

    clue(5'd14, 3'd0, 24'h000000);
    check("idx_empty", 64'(last_word[LW-1 -: 5]), 64'd14);
    check("n_empty", 64'(get_n(last_word)), 64'd1);
    check("lat_empty", 64'(ev_cyc + 1 - acc), 64'd3);

    clue(5'd0, 3'd1, 24'h00000B);
    check("n_full", 64'(get_n(last_word)), 64'd1);
    check("opt_full", 64'(get_opt(last_word, 0)), 64'b11111111111);

    clue(5'd7, 3'd2, 24'h000055);
    check("n_55", 64'(get_n(last_word)), 64'd1);
    check("opt_55", 64'(get_opt(last_word, 0)), 64'b11111011111);

    clue(5'd20, 3'd2, 24'h000022);
    check("n_22", 64'(get_n(last_word)), 64'd28);
    check("first_22", 64'(get_opt(last_word, 0)), 64'b11011000000);
    check("last_22", 64'(get_opt(last_word, 27)), 64'b00000011011);
    low = (LW'(1) << (OTOP + 1 - 28 * SIZE)) - LW'(1);
    check_word("unused_22", last_word & low, '0);
    check("lat_22", 64'(ev_cyc + 1 - acc), 64'd30);

    w0 = n_writes;
    send(5'd2, 3'd2, 24'h000056);
    check("inf_ready_low", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    check("inf_ready_back", 64'(in_ready), 64'd1);
    check("inf_pulse", 64'(err_infeasible), 64'd1);
    @(posedge clk); #1;
    check("inf_pulse_once", 64'(err_infeasible), 64'd0);
    check("inf_no_write", 64'(n_writes), 64'(w0));

    clue(5'd4, 3'd2, 24'h000003);
    check("zero_run_no_write", 64'(n_writes), 64'(w0));

    clue(5'd9, 3'd3, 24'h000111);
    check("n_111", 64'(get_n(last_word)), 64'd84);
    check("opt0_111", 64'(get_opt(last_word, 0)), 64'b10101000000);

    clue(5'd21, 3'd3, 24'h000213);

    fifo_full = 1;
    w0 = n_writes;
    send(5'd3, 3'd1, 24'h000003);
    repeat (10) @(posedge clk);
    #1;
    d0 = dout;
    stable = 1;
    repeat (20) begin
      @(posedge clk); #1;
      if (dout !== d0 || write_to_fifo !== 1'b0) stable = 0;
    end
    check("stall_stable", 64'(stable), 64'd1);
    check("stall_no_write", 64'(n_writes), 64'(w0));
    fifo_full = 0;
    wait_event(5);
    check("stall_release_cycle", 64'(ev_cyc - acc), 64'd30);
    repeat (3) @(posedge clk);
    #1;
    check("stall_one_write", 64'(n_writes), 64'(w0 + 1));

    e0 = n_events;
    send(5'd1, 3'd2, 24'h000011);
    repeat (5) @(posedge clk);
    #1;
    rst = 1;
    exp_q.delete();
    @(posedge clk); #1;
    rst = 0;
    check("abort_in_ready", 64'(in_ready), 64'd1);
    check("abort_busy", 64'(busy), 64'd0);
    repeat (60) @(posedge clk);
    #1;
    check("abort_no_event", 64'(n_events), 64'(e0));
    clue(5'd3, 3'd1, 24'h000003);
    check("after_abort_n", 64'(get_n(last_word)), 64'd9);

    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/line_option_generator.md
Name: line_option_generator

Overview:
- Upstream stage of fifo_solver. Takes one nonogram clue (line index plus run lengths) at a time and enumerates every legal placement of the runs in a SIZE-cell line.
- Packs the line index, option count and all options into one LINE_W-bit word and writes it to the line FIFO that fifo_solver pops.
- One option is produced per cycle. Infeasible or oversize clues are flagged and dropped.

Parameters:
- SIZE, 11: cells per row/column.
- MAX_RUNS, 6: maximum runs per clue; equals ceil(SIZE/2).
- RUN_W, 4: width of one run length; equals clog2(SIZE+1).
- IDX_W, 5: width of the line index; equals clog2(2*SIZE). Indices 0..SIZE-1 are rows, SIZE..2*SIZE-1 are columns.
- CNT_W, 7: width of the option count field.
- LINE_W, 1024: FIFO word width.
- MAX_OPTS, 92: option capacity; equals floor((LINE_W-IDX_W-CNT_W)/SIZE).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  clue presented.
- in_ready  out  1  generator can accept a clue.
- line_idx  in  IDX_W  line index of the clue.
- run_count  in  clog2(MAX_RUNS+1)  number of runs; 0 means an empty line.
- runs  in  MAX_RUNS*RUN_W  run lengths. Run 0 is in the LSBs. Run 0 is the leftmost/topmost run.
- fifo_full  in  1  line FIFO cannot accept a write.
- write_to_fifo  out  1  one-cycle write strobe.
- dout  out  LINE_W  packed line word; valid while write_to_fifo=1.
- busy  out  1  clue being processed.
- err_infeasible  out  1  one-cycle pulse; clue dropped because it does not fit.
- err_overflow  out  1  one-cycle pulse; clue dropped because it has more than MAX_OPTS options.

Behaviour:
- Reset:
  - All outputs are 0 except in_ready=1.
  - The internal word buffer, counters and state go to 0/IDLE.
  - Reset in any state aborts the clue. No partial write ever occurs.
- Word format:
  - dout[LINE_W-1 -: IDX_W] = line index.
  - Next CNT_W bits = option count N.
  - Option k (k=0..N-1) is at dout[LINE_W-1-IDX_W-CNT_W-k*SIZE -: SIZE].
  - All unused bits are 0.
  - Within an option, bit SIZE-1 is cell 0 (leftmost/top); 1 means filled.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready, latch the clue, clear the buffer and count, and go to INIT. in_ready drops the next cycle.
- INIT (1 cycle):
  - Compute need = sum(runs) + (run_count-1), with need=0 when run_count=0.
  - If need > SIZE: pulse err_infeasible and return to IDLE.
  - Otherwise set start[i] to the leftmost packing (start[0]=0, start[i]=start[i-1]+len[i-1]+1) and go to EMIT.
- EMIT (one option per cycle):
  - Render the current starts into a SIZE-bit mask and store it at slot N. Increment N.
  - If N would exceed MAX_OPTS: pulse err_overflow and return to IDLE without writing.
  - Advance: find the highest run k whose end start[k]+len[k] is below its limit. The limit is start[k+1]-1, or SIZE for the last run.
    - Set start[k]+=1.
    - Repack runs k+1.. leftmost directly after run k, each with a one-cell gap.
    - If no such k exists, or run_count=0 (single all-zero option), go to PUSH after storing.
- PUSH:
  - Present dout. Assert write_to_fifo for exactly one cycle, in the first cycle with fifo_full=0.
  - Hold while fifo_full=1.
  - Then go to IDLE.
- Latency: with the clue accepted at edge T, the write occurs in cycle T+2+N at the earliest. Stalls add cycles while fifo_full=1.
- busy = (state != IDLE). in_ready = (state == IDLE).
- The error pulses are mutually exclusive and never coincide with write_to_fifo.
- Run lengths of 0 inside run_count count as infeasible: pulse err_infeasible.

Test Plan:
- Clue idx=3, runs={3}: one write. Header idx=3, N=9. Option0=11100000000, option8=00000000111. The write lands 11 cycles after acceptance.
- Clue idx=14, run_count=0: N=1, option0=00000000000. Clue runs={11}: N=1, option0=11111111111.
- Clue runs={5,5}: N=1, option 11111011111. Clue runs={2,2}: N=28, first option 11011000000, last option 00000011011. All unused bits are 0.
- Clue runs={6,5}: err_infeasible pulses once, no write, in_ready returns after 2 cycles. Clue runs={1,1,1}: N=84, no overflow.
- Hold fifo_full=1 for 20 cycles at PUSH: write_to_fifo stays 0 and dout is stable. It strobes exactly once in the cycle after fifo_full falls.
- Assert rst mid-EMIT on clue {1,1}: the next cycle shows in_ready=1, busy=0, no write. A new clue {3} then produces a correct N=9 word.
